// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline register with 2-entry skid, flush squash counter and NOP bubble on empty.
// Latency 1 cycle; up_ready is registered (!skid_v) so dn_ready never reaches it combinationally.
module pipe_stage_skid #(
    parameter int                PC_W        = 32,
    parameter int                INST_W      = 32,
    parameter logic [INST_W-1:0] BUBBLE_INST = 32'h00000013,
    parameter int                CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              up_valid,
    output logic              up_ready,
    input  logic [PC_W-1:0]   up_pc,
    input  logic [INST_W-1:0] up_inst,
    output logic              dn_valid,
    input  logic              dn_ready,
    output logic [PC_W-1:0]   dn_pc,
    output logic [INST_W-1:0] dn_inst,
    input  logic              flush,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [CNT_W+1:0] CNT_MAX = {2'b00, {CNT_W{1'b1}}};

    logic              main_v_q, main_v_d;
    logic              skid_v_q, skid_v_d;
    logic [PC_W-1:0]   main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
    logic [INST_W-1:0] main_inst_q, main_inst_d, skid_inst_q, skid_inst_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic              up_xfer, dn_xfer;
    logic [1:0]        flush_inc;
    logic [CNT_W+1:0]  cnt_sum;

    assign up_ready  = ~skid_v_q & ~rst;
    assign up_xfer   = up_valid & up_ready;
    assign dn_xfer   = main_v_q & dn_ready;

    assign dn_valid  = main_v_q;
    assign dn_pc     = main_v_q ? main_pc_q : '0;
    assign dn_inst   = main_v_q ? main_inst_q : BUBBLE_INST;
    assign flush_cnt = flush_cnt_q;

    // Squashed = main not delivered this cycle, plus skid, plus any entry accepted alongside the flush.
    assign flush_inc = 2'(main_v_q & ~dn_xfer) + 2'(skid_v_q) + 2'(up_xfer);
    assign cnt_sum   = {2'b00, flush_cnt_q} + (CNT_W+2)'(flush_inc);

    always_comb begin
        main_v_d    = main_v_q;
        skid_v_d    = skid_v_q;
        main_pc_d   = main_pc_q;
        main_inst_d = main_inst_q;
        skid_pc_d   = skid_pc_q;
        skid_inst_d = skid_inst_q;
        flush_cnt_d = flush_cnt_q;

        if (flush) begin
            main_v_d    = 1'b0;
            skid_v_d    = 1'b0;
            flush_cnt_d = (cnt_sum > CNT_MAX) ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
        end else if (!main_v_q) begin
            if (up_xfer) begin
                main_v_d    = 1'b1;
                main_pc_d   = up_pc;
                main_inst_d = up_inst;
            end
        end else if (!skid_v_q) begin
            if (up_xfer && dn_xfer) begin
                main_pc_d   = up_pc;
                main_inst_d = up_inst;
            end else if (up_xfer) begin
                skid_v_d    = 1'b1;
                skid_pc_d   = up_pc;
                skid_inst_d = up_inst;
            end else if (dn_xfer) begin
                main_v_d    = 1'b0;
            end
        end else if (dn_xfer) begin
            main_pc_d   = skid_pc_q;
            main_inst_d = skid_inst_q;
            skid_v_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_v_q    <= 1'b0;
            skid_v_q    <= 1'b0;
            main_pc_q   <= '0;
            main_inst_q <= '0;
            skid_pc_q   <= '0;
            skid_inst_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            main_v_q    <= main_v_d;
            skid_v_q    <= skid_v_d;
            main_pc_q   <= main_pc_d;
            main_inst_q <= main_inst_d;
            skid_pc_q   <= skid_pc_d;
            skid_inst_q <= skid_inst_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // The skid slot only ever fills behind an occupied main slot.
    a_skid_needs_main: assert property (@(posedge clk) disable iff (rst) !(skid_v_q && !main_v_q));

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: streaming, backpressure, flush, reset and counter saturation.
module tb_pipe_stage_skid;

    logic        clk = 1'b0;
    logic        rst, up_valid, dn_ready, flush;
    logic [31:0] up_pc, up_inst;
    logic        up_ready, dn_valid, s_up_ready, s_dn_valid;
    logic [31:0] dn_pc, dn_inst, s_dn_pc, s_dn_inst;
    logic [15:0] flush_cnt;
    logic [1:0]  s_flush_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pipe_stage_skid u_dut (
        .clk(clk), .rst(rst),
        .up_valid(up_valid), .up_ready(up_ready), .up_pc(up_pc), .up_inst(up_inst),
        .dn_valid(dn_valid), .dn_ready(dn_ready), .dn_pc(dn_pc), .dn_inst(dn_inst),
        .flush(flush), .flush_cnt(flush_cnt)
    );

    pipe_stage_skid #(.CNT_W(2)) u_sat (
        .clk(clk), .rst(rst),
        .up_valid(up_valid), .up_ready(s_up_ready), .up_pc(up_pc), .up_inst(up_inst),
        .dn_valid(s_dn_valid), .dn_ready(dn_ready), .dn_pc(s_dn_pc), .dn_inst(s_dn_inst),
        .flush(flush), .flush_cnt(s_flush_cnt)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc);
        up_valid = 1'b1;
        up_pc    = pc;
        up_inst  = 32'hA000_0000 | pc;
    endtask

    initial begin
        rst = 1'b1; up_valid = 1'b0; dn_ready = 1'b0; flush = 1'b0;
        up_pc = '0; up_inst = '0;
        step();
        step();
        check("rst_up_ready", up_ready, 0);
        check("rst_dn_valid", dn_valid, 0);
        check("rst_dn_pc",    dn_pc,    0);
        check("rst_dn_inst",  dn_inst,  32'h13);
        check("rst_cnt",      flush_cnt, 0);

        rst = 1'b0;
        step();
        check("idle_up_ready", up_ready, 1);
        check("idle_dn_valid", dn_valid, 0);
        check("idle_dn_pc",    dn_pc,    0);
        check("idle_dn_inst",  dn_inst,  32'h13);

        // Back-to-back streaming at full rate
        dn_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push(32'(4 * i));
            check("stream_up_ready", up_ready, 1);
            step();
            check("stream_dn_valid", dn_valid, 1);
            check("stream_dn_pc",    dn_pc,    64'(4 * i));
            check("stream_dn_inst",  dn_inst,  64'(32'hA000_0000 | 32'(4 * i)));
        end
        up_valid = 1'b0;
        step();
        check("stream_drain", dn_valid, 0);

        // Backpressure: fills to TWO then drains in order
        dn_ready = 1'b0;
        push(32'h100);
        check("bp_rdy_a", up_ready, 1);
        step();
        push(32'h104);
        check("bp_rdy_b", up_ready, 1);
        step();
        push(32'h108);
        check("bp_rdy_c", up_ready, 0);
        check("bp_pc_c",  dn_pc, 32'h100);
        step();
        check("bp_hold_pc", dn_pc, 32'h100);
        dn_ready = 1'b1;
        step();
        check("bp_pc_d",  dn_pc, 32'h104);
        check("bp_rdy_d", up_ready, 1);
        step();
        up_valid = 1'b0;
        check("bp_pc_e",   dn_pc,   32'h108);
        check("bp_inst_e", dn_inst, 32'hA000_0108);
        step();
        check("bp_empty", dn_valid, 0);

        // Flush in TWO squashes both entries
        dn_ready = 1'b0;
        push(32'h200);
        step();
        push(32'h204);
        step();
        up_valid = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("fl2_dn_valid", dn_valid, 0);
        check("fl2_up_ready", up_ready, 1);
        check("fl2_cnt",      flush_cnt, 2);

        // Flush in ONE with delivery and a same-cycle accept: only the incoming entry counts
        push(32'h300);
        step();
        push(32'h304);
        dn_ready = 1'b1;
        flush = 1'b1;
        check("fl1_dn_pc", dn_pc, 32'h300);
        step();
        flush = 1'b0;
        up_valid = 1'b0;
        check("fl1_dn_valid", dn_valid, 0);
        check("fl1_cnt",      flush_cnt, 3);
        step();
        check("fl1_no_ghost", dn_valid, 0);

        // Held flush squashes each accepted entry
        dn_ready = 1'b0;
        flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push(32'h400 + 32'(4 * i));
            check("flh_up_ready", up_ready, 1);
            step();
            check("flh_dn_valid", dn_valid, 0);
        end
        flush = 1'b0;
        up_valid = 1'b0;
        check("flh_cnt", flush_cnt, 6);

        // Reset in TWO drops everything without counting
        push(32'h500);
        step();
        push(32'h504);
        step();
        check("rst2_pre_rdy", up_ready, 0);
        up_valid = 1'b0;
        rst = 1'b1;
        step();
        check("rst2_up_ready", up_ready, 0);
        check("rst2_dn_valid", dn_valid, 0);
        check("rst2_dn_pc",    dn_pc,    0);
        check("rst2_dn_inst",  dn_inst,  32'h13);
        check("rst2_cnt",      flush_cnt, 0);
        check("rst2_sat_cnt",  s_flush_cnt, 0);
        rst = 1'b0;
        dn_ready = 1'b1;
        step();
        check("rst2_rel_valid", dn_valid, 0);
        check("rst2_rel_ready", up_ready, 1);
        step();
        check("rst2_rel_valid2", dn_valid, 0);

        // Repeated single-entry flushes: 2-bit counter saturates at 3
        dn_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push(32'h600 + 32'(4 * i));
            step();
            up_valid = 1'b0;
            flush = 1'b1;
            step();
            flush = 1'b0;
            check("sat_cnt",  s_flush_cnt, (i < 3) ? 64'(i + 1) : 64'd3);
            check("wide_cnt", flush_cnt, 64'(i + 1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
Parametrised, flow-controlled pipeline stage register for the RISC_V core. It carries a PC/instruction pair between two stages using valid/ready handshakes instead of a global stall vector. A 2-entry skid buffer gives full throughput with a registered up_ready. It also provides flush, bubble-NOP injection and a saturating count of squashed entries. It is the drop-in building block for the IF/ID, ID/EX and later stage boundaries.

Parameters:
PC_W, 32, width of the PC field
INST_W, 32, width of the instruction/payload field
BUBBLE_INST, 32'h00000013, value driven on dn_inst when no valid entry is presented (RV32I NOP, addi x0,x0,0)
CNT_W, 16, width of the flush counter

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
up_valid  input  1  upstream presents an entry
up_ready  output  1  stage can accept an entry this cycle
up_pc  input  PC_W  upstream PC
up_inst  input  INST_W  upstream instruction
dn_valid  output  1  stage presents an entry downstream
dn_ready  input  1  downstream accepts the presented entry
dn_pc  output  PC_W  presented PC
dn_inst  output  INST_W  presented instruction
flush  input  1  squash all held and incoming entries (branch taken / redirect)
flush_cnt  output  CNT_W  saturating count of entries squashed by flush

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Transfers: up_xfer = up_valid & up_ready; dn_xfer = dn_valid & dn_ready. Payload is sampled only on up_xfer.
- Storage: main entry (main_v, main_pc, main_inst) and skid entry (skid_v, skid_pc, skid_inst).
- States: EMPTY (main_v=0, skid_v=0), ONE (main_v=1, skid_v=0), TWO (main_v=1, skid_v=1). skid_v=1 with main_v=0 is illegal; assertion required.
- Outputs:
  - dn_valid = main_v.
  - dn_pc = main_v ? main_pc : 0.
  - dn_inst = main_v ? main_inst : BUBBLE_INST.
  - up_ready = !skid_v & !rst. It depends only on registered state, so there is no combinational path from dn_ready to up_ready.
- Transitions when flush=0:
  - EMPTY + up_xfer: load main; go to ONE.
  - ONE + up_xfer + dn_xfer: load main with the new entry; stay in ONE.
  - ONE + up_xfer only: load skid; go to TWO.
  - ONE + dn_xfer only: go to EMPTY.
  - TWO + dn_xfer: main <= skid; go to ONE. up_ready=0, so no up_xfer is possible in TWO.
  - No events: hold state and payload.
- Latency: an entry accepted in cycle N is presented (dn_valid=1) in cycle N+1. Order is strictly FIFO. No entry is duplicated or dropped except by flush.
- Flush (priority below rst, above everything else):
  - Next state is EMPTY.
  - Any up_xfer in the same cycle completes (upstream sees the entry as consumed) but the entry is discarded.
  - A dn_xfer in the same cycle still counts as delivered to downstream.
  - flush_cnt += main_v (if not delivered by a same-cycle dn_xfer) + skid_v + up_xfer. The counter saturates at 2^CNT_W-1 and never wraps.
  - Flush held for several cycles keeps the stage EMPTY and squashes every accepted entry.
- Reset:
  - Effective at the rising edge with rst=1: main_v=0, skid_v=0, payload registers=0, flush_cnt=0.
  - While rst=1: up_ready=0, dn_valid=0, dn_pc=0, dn_inst=BUBBLE_INST.
  - Reset mid-operation drops both entries without counting them.
- Payload registers are not cleared on dn_xfer or flush; only the valid bits are cleared. The outputs are masked by main_v.

Test Plan:
- Reset release, then 8 back-to-back entries (pc 0x00,0x04,…,0x1C) with dn_ready=1 -> up_ready stays 1; dn_valid from cycle 1; dn_pc sequence 0x00..0x1C, one per cycle, in order.
- Streaming with dn_ready=0 for 3 cycles -> stage reaches TWO after 2 accepts; up_ready=0 on the 3rd cycle; after dn_ready=1, entries emerge in order with no loss or duplicate.
- Idle stage, up_valid=0 -> dn_valid=0, dn_pc=0, dn_inst=0x00000013.
- State TWO, flush=1 with dn_ready=0 -> next cycle dn_valid=0, up_ready=1, flush_cnt increments by 2. Separately, ONE with flush and up_xfer and dn_xfer -> flush_cnt increments by 1.
- CNT_W=2, repeated single-entry flushes -> flush_cnt goes 1,2,3,3 (saturates).
- rst asserted in state TWO mid-stream -> next cycle all outputs are at reset values, flush_cnt=0, and no entries appear after rst deasserts until new up_xfer occur.
